// File: rtl/raycast_pkg.sv
// Shared types and register-map constants for the column frame buffer.
// Bank role indices, status word field offsets and control bit positions.
package raycast_pkg;

    typedef logic [1:0] bank_idx_t;

    localparam int STATUS_COL_LSB   = 0;
    localparam int STATUS_COL_W     = 11;
    localparam int STATUS_READY_BIT = 11;
    localparam int STATUS_DROP_LSB  = 16;
    localparam int STATUS_DROP_W    = 16;

    localparam int CTRL_ABORT_BIT   = 0;
    localparam int CTRL_CLRDROP_BIT = 1;

    localparam logic [STATUS_DROP_W-1:0] DROP_MAX = '1;

endpackage

// File: rtl/column_bank.sv
// One column store: simple dual-port RAM, synchronous write and read.
// Contents are never cleared; readers mask stale data themselves.
module column_bank #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 29,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // write port and registered read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/column_frame_buffer.sv
// Triple-buffered column store between the Avalon writer and the pixel pipe.
// Rotates write/pending/display banks; display swaps only on frame_start.
module column_frame_buffer
    import raycast_pkg::*;
#(
    parameter int NUM_COLS = 640,
    parameter int COL_W    = 29,
    parameter int WORD_W   = 16,
    localparam int WORDS_PER_COL = (COL_W + WORD_W - 1) / WORD_W,
    localparam int COL_AW        = $clog2(NUM_COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic              address,
    input  logic [WORD_W-1:0] writedata,
    output logic [31:0]       readdata,
    input  logic              frame_start,
    input  logic [COL_AW-1:0] rd_col,
    output logic [COL_W-1:0]  rd_data,
    output logic              swap_pulse,
    output logic              frame_ready
);

    localparam int ASM_W = WORDS_PER_COL * WORD_W;
    localparam int WC_W  = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;
    localparam logic [COL_AW-1:0] LAST_COL  = COL_AW'(NUM_COLS - 1);
    localparam logic [WC_W-1:0]   LAST_WORD = WC_W'(WORDS_PER_COL - 1);

    typedef logic [ASM_W-1:0] asm_t;

    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic [COL_AW-1:0] wr_col_q, wr_col_d;
    asm_t              asm_q, asm_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              frame_ready_q, frame_ready_d;
    logic              swap_pulse_q, swap_pulse_d;
    bank_idx_t         disp_b_q, disp_b_d;
    bank_idx_t         wr_b_q, wr_b_d;
    bank_idx_t         pend_b_q, pend_b_d;
    logic [31:0]       readdata_q, readdata_d;
    bank_idx_t         rd_sel_q, rd_sel_d;
    logic              rd_ok_q, rd_ok_d;

    logic              data_we, ctrl_we, stat_rd;
    logic              rec_we, frame_done;
    asm_t              asm_full;
    logic [2:0]        bank_we;
    logic [COL_W-1:0]  bank_rd [3];
    logic [COL_W-1:0]  rd_mux;

    assign data_we    = chipselect & write & ~address;
    assign ctrl_we    = chipselect & write & address;
    assign stat_rd    = chipselect & read & address;
    assign asm_full   = asm_t'({asm_q, writedata});
    assign rec_we     = data_we && (word_cnt_q == LAST_WORD);
    assign frame_done = rec_we && (wr_col_q == LAST_COL);

    // record assembly, bank role rotation, drop counting and status
    always_comb begin
        word_cnt_d    = word_cnt_q;
        wr_col_d      = wr_col_q;
        asm_d         = asm_q;
        drop_cnt_d    = drop_cnt_q;
        frame_ready_d = frame_ready_q;
        swap_pulse_d  = 1'b0;
        disp_b_d      = disp_b_q;
        wr_b_d        = wr_b_q;
        pend_b_d      = pend_b_q;
        readdata_d    = '0;
        rd_sel_d      = disp_b_q;
        rd_ok_d       = {1'b0, rd_col} < (COL_AW + 1)'(NUM_COLS);

        if (data_we) begin
            asm_d = asm_full;
            if (rec_we) begin
                word_cnt_d = '0;
                wr_col_d   = frame_done ? '0 : wr_col_q + COL_AW'(1);
            end else begin
                word_cnt_d = word_cnt_q + WC_W'(1);
            end
        end

        if (ctrl_we) begin
            if (writedata[CTRL_ABORT_BIT]) begin
                word_cnt_d = '0;
                wr_col_d   = '0;
            end
            if (writedata[CTRL_CLRDROP_BIT]) begin
                drop_cnt_d = '0;
            end
        end

        if (frame_done && frame_start) begin
            swap_pulse_d = 1'b1;
            wr_b_d       = disp_b_q;
            if (frame_ready_q) begin
                disp_b_d = pend_b_q;
                pend_b_d = wr_b_q;
            end else begin
                disp_b_d = wr_b_q;
            end
        end else if (frame_done) begin
            wr_b_d        = pend_b_q;
            pend_b_d      = wr_b_q;
            frame_ready_d = 1'b1;
            if (frame_ready_q && drop_cnt_q != DROP_MAX) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (frame_start && frame_ready_q) begin
            swap_pulse_d  = 1'b1;
            disp_b_d      = pend_b_q;
            pend_b_d      = disp_b_q;
            frame_ready_d = 1'b0;
        end

        if (stat_rd) begin
            readdata_d[STATUS_DROP_LSB +: STATUS_DROP_W] = drop_cnt_q;
            readdata_d[STATUS_READY_BIT]                 = frame_ready_q;
            readdata_d[STATUS_COL_LSB +: COL_AW]         = wr_col_q;
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt_q    <= '0;
            wr_col_q      <= '0;
            asm_q         <= '0;
            drop_cnt_q    <= '0;
            frame_ready_q <= 1'b0;
            swap_pulse_q  <= 1'b0;
            disp_b_q      <= 2'd0;
            wr_b_q        <= 2'd1;
            pend_b_q      <= 2'd2;
            readdata_q    <= '0;
            rd_sel_q      <= 2'd0;
            rd_ok_q       <= 1'b0;
        end else begin
            word_cnt_q    <= word_cnt_d;
            wr_col_q      <= wr_col_d;
            asm_q         <= asm_d;
            drop_cnt_q    <= drop_cnt_d;
            frame_ready_q <= frame_ready_d;
            swap_pulse_q  <= swap_pulse_d;
            disp_b_q      <= disp_b_d;
            wr_b_q        <= wr_b_d;
            pend_b_q      <= pend_b_d;
            readdata_q    <= readdata_d;
            rd_sel_q      <= rd_sel_d;
            rd_ok_q       <= rd_ok_d;
        end
    end

    // completed records go only to the current write bank
    always_comb begin
        for (int b = 0; b < 3; b++) begin
            bank_we[b] = rec_we && !reset && (wr_b_q == bank_idx_t'(b));
        end
    end

    for (genvar b = 0; b < 3; b++) begin : g_bank
        column_bank #(
            .DEPTH (NUM_COLS),
            .WIDTH (COL_W),
            .AW    (COL_AW)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .waddr (wr_col_q),
            .wdata (asm_full[COL_W-1:0]),
            .raddr (rd_col),
            .rdata (bank_rd[b])
        );
    end

    // select the bank that was on display when the read was issued
    always_comb begin
        rd_mux = '0;
        case (rd_sel_q)
            2'd0:    rd_mux = bank_rd[0];
            2'd1:    rd_mux = bank_rd[1];
            2'd2:    rd_mux = bank_rd[2];
            default: rd_mux = '0;
        endcase
    end

    assign rd_data     = rd_ok_q ? rd_mux : '0;
    assign readdata    = readdata_q;
    assign swap_pulse  = swap_pulse_q;
    assign frame_ready = frame_ready_q;

endmodule
